// File: rtl/map_alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states, default width.
package map_alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [4:0] {
      MODE_SRL  = 5'd0,
      MODE_SRA  = 5'd1,
      MODE_SRRL = 5'd2,
      MODE_SRRA = 5'd3,
      MODE_SLL  = 5'd4,
      MODE_SLA  = 5'd5,
      MODE_SLRL = 5'd6,
      MODE_SLRA = 5'd7,
      MODE_MOV  = 5'd8,
      MODE_NOT  = 5'd9,
      MODE_INC  = 5'd10,
      MODE_DEC  = 5'd11,
      MODE_CLR  = 5'd12,
      MODE_AND  = 5'd13,
      MODE_OR   = 5'd14,
      MODE_ADD  = 5'd15,
      MODE_SUB  = 5'd16,
      MODE_CLE  = 5'd17,
      MODE_CLZ  = 5'd18,
      MODE_MUL  = 5'd19
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_MUL,
      ST_DONE
   } state_e;

   // The eight shift codes occupy 0..7, so the low three bits select the step.
   function automatic logic is_shift(input logic [4:0] m);
      return (m[4:3] == 2'b00);
   endfunction

   // Single-cycle modes whose Z follows the result.
   function automatic logic is_data(input logic [4:0] m);
      return (m >= MODE_MOV) && (m <= MODE_SUB);
   endfunction

endpackage

// File: rtl/map_alu_shift_step.sv
// One combinational 1-bit shift/rotate step for all eight shift modes.
module map_alu_shift_step
   import map_alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] nxt_value,
   output logic             out_bit
);

   always_comb begin
      nxt_value = value;
      out_bit   = 1'b0;
      case ({2'b00, op})
         MODE_SRL: begin
            nxt_value = {1'b0, value[WIDTH-1:1]};
            out_bit   = value[0];
         end
         MODE_SRA: begin
            nxt_value = {value[WIDTH-1], value[WIDTH-1:1]};
            out_bit   = value[0];
         end
         MODE_SRRL: begin
            nxt_value = {value[0], value[WIDTH-1:1]};
            out_bit   = value[0];
         end
         MODE_SRRA: begin
            nxt_value = {value[WIDTH-1], value[0], value[WIDTH-2:1]};
            out_bit   = value[0];
         end
         MODE_SLL, MODE_SLA: begin
            nxt_value = {value[WIDTH-2:0], 1'b0};
            out_bit   = value[WIDTH-1];
         end
         MODE_SLRL: begin
            nxt_value = {value[WIDTH-2:0], value[WIDTH-1]};
            out_bit   = value[WIDTH-1];
         end
         // Arithmetic rotate-left: MSB is held, bits [WIDTH-2:0] rotate.
         MODE_SLRA: begin
            nxt_value = {value[WIDTH-1], value[WIDTH-3:0], value[WIDTH-2]};
            out_bit   = value[WIDTH-2];
         end
         default: begin
            nxt_value = value;
            out_bit   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/map_alu_seq.sv
// Sequential ALU with valid/ready handshake; shifts take one cycle per bit.
// Optional shift-add multiplier enabled by defining MAP_ALU_MUL_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready high
// ST_SHIFT | one 1-bit shift step per cycle, cnt counts down remaining steps
// ST_MUL   | one shift-add multiply step per cycle (MAP_ALU_MUL_EN only)
// ST_DONE  | result held on odata/e/z, out_valid high until out_ready
module map_alu_seq
   import map_alu_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] odata,
   output logic             e,
   output logic             z
);

   localparam int CNT_MIN = $clog2(WIDTH + 1);
   localparam int CNT_W   = (SHAMT_W > CNT_MIN) ? SHAMT_W : CNT_MIN;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e             state, state_nxt;
   logic [2:0]         shop_q;
   logic [WIDTH-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               e_q, z_q;
   logic               accept, last;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   res, step_val;
   logic [WIDTH:0]     sum;
   logic               res_e, res_z, step_out;

   assign shamt     = b[SHAMT_W-1:0];
   assign in_ready  = rst_n && (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == CNT_W'(1));
   assign odata     = acc;
   assign e         = e_q;
   assign z         = z_q;

   map_alu_shift_step #(.WIDTH(WIDTH)) u_step (
      .op        (shop_q),
      .value     (acc),
      .nxt_value (step_val),
      .out_bit   (step_out)
   );

`ifdef MAP_ALU_MUL_EN
   logic [WIDTH-1:0] mul_hi, mul_b;
   logic [WIDTH:0]   mul_sum;
   assign mul_sum = {1'b0, mul_hi} + (acc[0] ? {1'b0, mul_b} : '0);
`endif

   always_comb begin
      res   = '0;
      res_e = e_q;
      res_z = z_q;
      sum   = {1'b0, a} + {1'b0, b};
      case (mode)
         MODE_MOV: res = a;
         MODE_NOT: res = ~a;
         MODE_INC: begin
            sum   = {1'b0, a} + {1'b0, ONE};
            res   = sum[WIDTH-1:0];
            res_e = sum[WIDTH];
         end
         MODE_DEC: begin
            res   = a - ONE;
            res_e = (a == '0);
         end
         MODE_CLR: res = '0;
         MODE_AND: res = a & b;
         MODE_OR:  res = a | b;
         MODE_ADD: begin
            res   = sum[WIDTH-1:0];
            res_e = sum[WIDTH];
         end
         MODE_SUB: begin
            res   = a - b;
            res_e = (a < b);
         end
         MODE_CLE: begin
            res   = a;
            res_e = 1'b0;
         end
         MODE_CLZ: res = a;
         default:  res = '0;
      endcase
      if (is_data(mode)) res_z = (res == '0);
      if (mode == MODE_CLZ) res_z = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_shift(mode) && (shamt != '0)) state_nxt = ST_SHIFT;
`ifdef MAP_ALU_MUL_EN
               else if (mode == MODE_MUL) state_nxt = ST_MUL;
`endif
               else state_nxt = ST_DONE;
            end
         end
         ST_SHIFT: if (last) state_nxt = ST_DONE;
`ifdef MAP_ALU_MUL_EN
         ST_MUL:   if (last) state_nxt = ST_DONE;
`endif
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shop_q <= '0;
         acc    <= '0;
         cnt    <= '0;
         e_q    <= 1'b0;
         z_q    <= 1'b0;
`ifdef MAP_ALU_MUL_EN
         mul_hi <= '0;
         mul_b  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shop_q <= mode[2:0];
                  if (is_shift(mode)) begin
                     acc <= a;
                     cnt <= CNT_W'(shamt);
                     if (shamt == '0) z_q <= (a == '0);
                  end
`ifdef MAP_ALU_MUL_EN
                  else if (mode == MODE_MUL) begin
                     acc    <= a;
                     mul_hi <= '0;
                     mul_b  <= b;
                     cnt    <= CNT_W'(WIDTH);
                  end
`endif
                  else begin
                     acc <= res;
                     e_q <= res_e;
                     z_q <= res_z;
                  end
               end
            end
            ST_SHIFT: begin
               acc <= step_val;
               cnt <= cnt - CNT_W'(1);
               if (last) begin
                  e_q <= step_out;
                  z_q <= (step_val == '0);
               end
            end
`ifdef MAP_ALU_MUL_EN
            // {mul_hi, acc} shifts right each step; acc starts as the multiplier.
            ST_MUL: begin
               {mul_hi, acc} <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt - CNT_W'(1);
               if (last) begin
                  e_q <= (mul_sum[WIDTH:1] != '0);
                  z_q <= ({mul_sum[0], acc[WIDTH-1:1]} == '0);
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_map_alu_seq.sv
// Directed bench for map_alu_seq at WIDTH=8; expectations follow MAP_ALU_MUL_EN.
module tb_map_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] mode;
   logic [7:0] a, b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] odata;
   logic       e, z;

   int n_total = 0;
   int n_bad   = 0;

   map_alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .odata     (odata),
      .e         (e),
      .z         (z)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [4:0] m, input logic [7:0] av,
                         input logic [7:0] bv, input int lat, input logic [7:0] d,
                         input logic ee, input logic zz, input int hold);
      int cyc;
      @(negedge clk);
      check({tag, " rdy"}, 32'(in_ready), 32'd1);
      mode     = m;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      mode     = 5'($urandom);
      check({tag, " busy"}, 32'(in_ready), 32'd0);
      cyc = 1;
      while (!out_valid && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " lat"}, 32'(cyc), 32'(lat));
      check({tag, " data"}, 32'(odata), 32'(d));
      check({tag, " e"}, 32'(e), 32'(ee));
      check({tag, " z"}, 32'(z), 32'(zz));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold"}, {21'd0, out_valid, in_ready, e, z, odata}, {21'd0, 1'b1, 1'b0, ee, zz, d});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      mode      = '0;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      check("reset", {27'd0, in_ready, out_valid, e, z, odata == 8'd0}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset rdy", 32'(in_ready), 32'd1);

      //      tag      mode   A      B      lat d      e     z     hold
      run_op("add",   5'd15, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1, 0);
      run_op("and",   5'd13, 8'h0F, 8'hF0, 1, 8'h00, 1'b1, 1'b1, 0);
      run_op("cle",   5'd17, 8'h33, 8'h00, 1, 8'h33, 1'b0, 1'b1, 0);
      run_op("sra",   5'd1,  8'h80, 8'h03, 4, 8'hF0, 1'b0, 1'b0, 0);
      run_op("srrl",  5'd2,  8'h01, 8'h01, 2, 8'h80, 1'b1, 1'b0, 0);
      run_op("subeq", 5'd16, 8'h05, 8'h05, 1, 8'h00, 1'b0, 1'b1, 5);
      run_op("inc",   5'd10, 8'h7F, 8'h00, 1, 8'h80, 1'b0, 1'b0, 0);
      run_op("sub",   5'd16, 8'h03, 8'h05, 1, 8'hFE, 1'b1, 1'b0, 0);
      run_op("clz",   5'd18, 8'h00, 8'h00, 1, 8'h00, 1'b1, 1'b0, 0);
      run_op("slra",  5'd7,  8'hC1, 8'h02, 3, 8'h86, 1'b0, 1'b0, 0);
      run_op("srra",  5'd3,  8'h81, 8'h01, 2, 8'hC0, 1'b1, 1'b0, 0);
      run_op("sll0",  5'd4,  8'h81, 8'h00, 1, 8'h81, 1'b1, 1'b0, 0);
      run_op("slrl",  5'd6,  8'h81, 8'h01, 2, 8'h03, 1'b1, 1'b0, 0);
      run_op("srl7",  5'd0,  8'h81, 8'h07, 8, 8'h01, 1'b0, 1'b0, 0);
      run_op("sll7",  5'd4,  8'h03, 8'h07, 8, 8'h80, 1'b1, 1'b0, 0);
      run_op("sla7",  5'd5,  8'h01, 8'h07, 8, 8'h80, 1'b0, 1'b0, 0);
      run_op("dec",   5'd11, 8'h00, 8'h00, 1, 8'hFF, 1'b1, 1'b0, 0);
      run_op("mov",   5'd8,  8'h00, 8'h00, 1, 8'h00, 1'b1, 1'b1, 0);
      run_op("or",    5'd14, 8'h00, 8'h00, 1, 8'h00, 1'b1, 1'b1, 0);
      run_op("not",   5'd9,  8'h0F, 8'h00, 1, 8'hF0, 1'b1, 1'b0, 0);
      run_op("undef", 5'd20, 8'h55, 8'hAA, 1, 8'h00, 1'b1, 1'b0, 0);
      run_op("undf31",5'd31, 8'h55, 8'hAA, 1, 8'h00, 1'b1, 1'b0, 0);
      run_op("clr",   5'd12, 8'h55, 8'h00, 1, 8'h00, 1'b1, 1'b1, 0);
      run_op("sub2",  5'd16, 8'h03, 8'h05, 1, 8'hFE, 1'b1, 1'b0, 0);
`ifdef MAP_ALU_MUL_EN
      run_op("mul",   5'd19, 8'h10, 8'h20, 9, 8'h00, 1'b1, 1'b1, 0);
      run_op("mul2",  5'd19, 8'h0F, 8'h03, 9, 8'h2D, 1'b0, 1'b0, 0);
`else
      run_op("mul",   5'd19, 8'h10, 8'h20, 1, 8'h00, 1'b1, 1'b0, 0);
      run_op("mul2",  5'd19, 8'h0F, 8'h03, 1, 8'h00, 1'b1, 1'b0, 0);
`endif
      run_op("add2",  5'd15, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1, 0);

      // Abort a long shift with reset in its second cycle.
      @(negedge clk);
      mode     = 5'd4;
      a        = 8'h81;
      b        = 8'h07;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("abort rst", {27'd0, in_ready, out_valid, e, z, odata != 8'd0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort rdy", {29'd0, in_ready, e, z}, 32'd4);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("abort noresult", 32'(seen), 32'd0);
      check("abort data", 32'(odata), 32'd0);

      run_op("post",  5'd15, 8'h01, 8'h01, 1, 8'h02, 1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/map_alu_seq.md
MAP_ALU_SEQ -- requirements
Module: map_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal values 4..32).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width taken from B.
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 IN_VALID  input  1  request present; IN_READY  output  1  block can accept.
REQ-006 MODE  input  5  operation code (numbering in REQ-010).
REQ-007 A, B  input  WIDTH each  operands; B[SHAMT_W-1:0] is the shift amount for shift modes.
REQ-008 OUT_VALID  output  1  result present; OUT_READY  input  1  consumer takes result.
REQ-009 oData  output  WIDTH  result; E  output  1  carry/borrow/shift-out flag; Z  output  1  zero flag.

Function
REQ-010 MODE codes SHALL be: SRL 0, SRA 1, SRRL 2, SRRA 3, SLL 4, SLA 5, SLRL 6, SLRA 7, MOV 8, NOT 9, INC 10, DEC 11, CLR 12, AND 13, OR 14, ADD 15, SUB 16, CLE 17, CLZ 18, MUL 19.
REQ-011 FSM SHALL have states IDLE, SHIFT, MUL, DONE; IN_READY = 1 only in IDLE; OUT_VALID = 1 only in DONE.
REQ-012 Accept SHALL occur on a rising edge with IN_VALID & IN_READY; MODE, A, B are captured on that edge.
REQ-013 Non-shift, non-MUL modes SHALL go IDLE->DONE on the accept edge (OUT_VALID in the next cycle, latency 1).
REQ-014 Shift modes with amount n>0 SHALL go IDLE->SHIFT, perform one 1-bit step per cycle for n cycles, then go to DONE; latency n+1; n=0 goes directly to DONE with oData=A and E unchanged.
REQ-015 SRL/SLL: logical, zero fill; SRA: sign fill; SLA: identical to SLL; SRRL/SLRL: rotate all WIDTH bits; SRRA/SLRA: rotate bits [WIDTH-2:0] with MSB held.
REQ-016 Shift E SHALL equal the last bit shifted/rotated out of the active field.
REQ-017 ADD/INC: E = carry out of bit WIDTH-1; SUB/DEC: E = borrow (A < B unsigned, or A == 0 for DEC); results are modulo 2^WIDTH.
REQ-018 MOV, NOT, CLR, AND, OR SHALL leave E unchanged.
REQ-019 Every data mode SHALL set Z = (oData == 0) on entry to DONE.
REQ-020 CLE SHALL give oData=A, E=0, Z unchanged; CLZ SHALL give oData=A, Z=0, E unchanged.
REQ-021 Undefined MODE SHALL complete in 1 cycle with oData=0 and E, Z unchanged; the block SHALL never hang.
REQ-022 DONE SHALL hold oData/E/Z stable until OUT_READY=1, then return to IDLE on that edge; the next accept is earliest on the following edge.
REQ-023 E and Z SHALL be registers that persist between operations; they change only on entry to DONE.
REQ-024 IN_VALID SHALL be ignored outside IDLE; inputs may change freely after accept.

Reset
REQ-025 With RST_N low: state=IDLE, oData=0, E=0, Z=0, OUT_VALID=0, IN_READY=0; IN_READY=1 from the first cycle after deassertion.
REQ-026 Reset asserted mid-SHIFT/MUL/DONE SHALL abort the operation with no result delivered.

Configuration
REQ-027 Macro MAP_ALU_MUL_EN defined: MUL is an unsigned shift-add multiply, WIDTH cycles in MUL state; oData = low WIDTH bits of the product, E = (high half != 0), Z per REQ-019; latency WIDTH+1.
REQ-028 Macro MAP_ALU_MUL_EN undefined: MUL state and its datapath are absent; MODE 19 behaves per REQ-021.

Structure
REQ-029 Package map_alu_pkg SHALL hold the MODE code constants/enum, the FSM state enum and the default WIDTH.
REQ-030 Sub-module map_alu_shift_step SHALL implement one combinational 1-bit step for all eight shift modes, returning the next value and the shifted-out bit.

Verification
REQ-031 WIDTH=8, ADD A=0xFF B=0x01 -> OUT_VALID after 1 cycle, oData=0x00, E=1, Z=1.
REQ-032 SRA A=0x80 B=3 -> OUT_VALID after 4 cycles, oData=0xF0, E=0, Z=0; SRRL A=0x01 B=1 -> oData=0x80, E=1.
REQ-033 SUB A=0x05 B=0x05 with OUT_READY held low 5 cycles -> oData=0x00, E=0, Z=1 stable throughout; IN_READY=0 until 1 cycle after release.
REQ-034 Flags E=1, Z=1; run CLE -> E=0, Z=1; run AND A=0x0F B=0xF0 -> Z=1, E unchanged.
REQ-035 MUL A=0x10 B=0x20 with MAP_ALU_MUL_EN -> 9-cycle latency, oData=0x00, E=1, Z=1; without the macro -> 1-cycle latency, oData=0, flags unchanged.
REQ-036 RST_N pulsed low in the 2nd cycle of SLL B=7 -> OUT_VALID never rises for that operation; oData=0, E=0, Z=0, IN_READY=1 after release.
